// File: rtl/xif_coproc_arbiter.sv
// -----------------------------------------------------------------------------
// xif_coproc_arbiter
//   Shares one CORE-V-XIF coprocessor between NUM_REQ CPU-side X-IF masters.
//   It handles only the issue, commit and result channels. Arbitration is
//   round-robin, with a single transaction in flight at a time. Commit and
//   result traffic is routed back to the requester that owns the transaction.
//
// Parameters
//   NUM_REQ        number of requesters (2..8)
//   ID_W           X-IF instruction id width
//   TIMEOUT_CYCLES result watchdog limit (only with XIF_ARB_TIMEOUT_EN)
//
// Ports
//   clk_i, rst_i           clock, async active-high reset
//   req_issue_*            per-requester issue handshake + payload (packed)
//   req_resp_*             broadcast accept/writeback, qualified by handshake
//   req_commit_*           per-requester commit valid/kill
//   req_result_*           per-requester result valid/ready, broadcast fields
//   cp_*                   single X-IF master port toward the coprocessor
//   busy_o, owner_o        transaction in flight / current owner
//   id_err_o, timeout_o    sticky result-id mismatch / watchdog flags
//
// Optional feature
//   `define XIF_ARB_TIMEOUT_EN builds the WAIT_RESULT watchdog. Without it
//   timeout_o is tied to 0 and WAIT_RESULT waits indefinitely.
// -----------------------------------------------------------------------------
module xif_coproc_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_issue_valid_i,
  output logic [NUM_REQ-1:0]         req_issue_ready_o,
  input  logic [NUM_REQ*32-1:0]      req_instr_i,
  input  logic [NUM_REQ*ID_W-1:0]    req_id_i,
  input  logic [NUM_REQ*64-1:0]      req_rs_i,
  input  logic [NUM_REQ*2-1:0]       req_rs_valid_i,
  output logic                       req_resp_accept_o,
  output logic                       req_resp_writeback_o,
  input  logic [NUM_REQ-1:0]         req_commit_valid_i,
  input  logic [NUM_REQ-1:0]         req_commit_kill_i,
  output logic [NUM_REQ-1:0]         req_result_valid_o,
  input  logic [NUM_REQ-1:0]         req_result_ready_i,
  output logic [31:0]                req_result_data_o,
  output logic [4:0]                 req_result_rd_o,
  output logic                       req_result_we_o,
  output logic [ID_W-1:0]            req_result_id_o,
  output logic                       cp_issue_valid_o,
  input  logic                       cp_issue_ready_i,
  output logic [31:0]                cp_instr_o,
  output logic [ID_W-1:0]            cp_id_o,
  output logic [63:0]                cp_rs_o,
  output logic [1:0]                 cp_rs_valid_o,
  input  logic                       cp_resp_accept_i,
  input  logic                       cp_resp_writeback_i,
  output logic                       cp_commit_valid_o,
  output logic                       cp_commit_kill_o,
  output logic [ID_W-1:0]            cp_commit_id_o,
  input  logic                       cp_result_valid_i,
  output logic                       cp_result_ready_o,
  input  logic [31:0]                cp_result_data_i,
  input  logic [4:0]                 cp_result_rd_i,
  input  logic                       cp_result_we_i,
  input  logic [ID_W-1:0]            cp_result_id_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       id_err_o,
  output logic                       timeout_o
);

  localparam int OW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_WCOMMIT  = 2'd2;
  localparam logic [1:0] S_WRESULT  = 2'd3;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("xif_coproc_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("xif_coproc_arbiter: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  logic [1:0]      r_state, w_state_nxt;
  logic [OW-1:0]   r_rr_ptr, r_owner;
  logic [ID_W-1:0] r_id;
  logic            r_accept, r_wb, r_id_err;

  logic            w_any;
  logic [OW-1:0]   w_grant, w_grant_nxt;
  logic            w_own_iv, w_own_cv, w_own_kill, w_own_rr;
  logic [ID_W-1:0] w_own_id;
  logic            w_iss_hs, w_commit_fire, w_res_hs;
  logic            w_tbeat, w_tbeat_done;

  // Round-robin search starting at r_rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_any && req_issue_valid_i[idx]) begin
        w_any   = 1'b1;
        w_grant = idx[OW-1:0];
      end
    end
    w_grant_nxt = (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + OW'(1);
  end

  assign w_own_iv   = req_issue_valid_i[r_owner];
  assign w_own_cv   = req_commit_valid_i[r_owner];
  assign w_own_kill = req_commit_kill_i[r_owner];
  assign w_own_rr   = req_result_ready_i[r_owner];
  assign w_own_id   = req_id_i[r_owner*ID_W +: ID_W];

  assign w_iss_hs      = (r_state == S_ISSUE) && w_own_iv && cp_issue_ready_i;
  // A commit presented together with the issue handshake is forwarded at once.
  assign w_commit_fire = ((r_state == S_ISSUE) && w_iss_hs && w_own_cv) ||
                         ((r_state == S_WCOMMIT) && w_own_cv);
  // The watchdog beat takes over the result port, so the cp result is ignored.
  assign w_res_hs      = (r_state == S_WRESULT) && !w_tbeat &&
                         cp_result_valid_i && w_own_rr;
  assign w_tbeat_done  = w_tbeat && w_own_rr;

`ifdef XIF_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tcnt;
  logic        r_timeout;

  // The counter is held at 0 outside WAIT_RESULT, so it starts from 0 on entry.
  // It saturates at TO_LAST while the watchdog beat waits for ready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state != S_WRESULT)                r_tcnt <= '0;
      else if (!w_res_hs && r_tcnt != TO_LAST) r_tcnt <= r_tcnt + 16'd1;
      if (w_tbeat_done) r_timeout <= 1'b1;
    end
  end

  assign w_tbeat   = (r_state == S_WRESULT) && (r_tcnt == TO_LAST);
  assign timeout_o = r_timeout;
`else
  assign w_tbeat   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (!w_own_iv) w_state_nxt = S_IDLE;  // requester withdrew the issue
        else if (w_iss_hs) begin
          if (!w_own_cv) w_state_nxt = S_WCOMMIT;
          else if (w_own_kill || !cp_resp_accept_i || !cp_resp_writeback_i)
            w_state_nxt = S_IDLE;
          else w_state_nxt = S_WRESULT;
        end
      end
      S_WCOMMIT: if (w_own_cv)
        w_state_nxt = (w_own_kill || !r_accept || !r_wb) ? S_IDLE : S_WRESULT;
      S_WRESULT: if (w_res_hs || w_tbeat_done) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_id     <= '0;
      r_accept <= 1'b0;
      r_wb     <= 1'b0;
      r_id_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any) begin
        r_owner  <= w_grant;
        r_rr_ptr <= w_grant_nxt;
      end
      if (w_iss_hs) begin
        r_id     <= w_own_id;
        r_accept <= cp_resp_accept_i;
        r_wb     <= cp_resp_writeback_i;
      end
      if (w_res_hs && cp_result_id_i != r_id) r_id_err <= 1'b1;
    end
  end

  // Outputs are gated by state, so everything is 0 in IDLE and during reset.
  always_comb begin
    req_issue_ready_o    = '0;
    req_resp_accept_o    = 1'b0;
    req_resp_writeback_o = 1'b0;
    cp_issue_valid_o     = 1'b0;
    cp_instr_o           = '0;
    cp_id_o              = '0;
    cp_rs_o              = '0;
    cp_rs_valid_o        = '0;
    cp_commit_valid_o    = w_commit_fire;
    cp_commit_kill_o     = w_commit_fire & w_own_kill;
    cp_commit_id_o       = '0;
    req_result_valid_o   = '0;
    cp_result_ready_o    = 1'b0;
    req_result_data_o    = '0;
    req_result_rd_o      = '0;
    req_result_we_o      = 1'b0;
    req_result_id_o      = '0;
    case (r_state)
      S_ISSUE: begin
        cp_issue_valid_o           = w_own_iv;
        cp_instr_o                 = req_instr_i[r_owner*32 +: 32];
        cp_id_o                    = w_own_id;
        cp_rs_o                    = req_rs_i[r_owner*64 +: 64];
        cp_rs_valid_o              = req_rs_valid_i[r_owner*2 +: 2];
        req_issue_ready_o[r_owner] = cp_issue_ready_i;
        req_resp_accept_o          = w_iss_hs & cp_resp_accept_i;
        req_resp_writeback_o       = w_iss_hs & cp_resp_writeback_i;
        cp_commit_id_o             = w_own_id;
      end
      S_WCOMMIT: cp_commit_id_o = r_id;
      S_WRESULT: begin
        if (w_tbeat) begin
          req_result_valid_o[r_owner] = 1'b1;
          req_result_id_o             = r_id;
        end else begin
          req_result_valid_o[r_owner] = cp_result_valid_i;
          cp_result_ready_o           = w_own_rr;
          req_result_data_o           = cp_result_data_i;
          req_result_rd_o             = cp_result_rd_i;
          req_result_we_o             = cp_result_we_i;
          req_result_id_o             = cp_result_id_i;
        end
      end
      default: ;
    endcase
  end

  assign busy_o   = (r_state != S_IDLE);
  assign owner_o  = r_owner;
  assign id_err_o = r_id_err;

endmodule

// File: tb/tb_xif_coproc_arbiter.sv
// Directed + randomized bench for xif_coproc_arbiter (NUM_REQ=2, ID_W=4).
// The reference model tracks the round-robin pointer as an integer and derives
// the expected owner, routing, next-state outcome and sticky flags directly
// from the transaction rules.
module tb_xif_coproc_arbiter;
  localparam int N  = 2;
  localparam int IW = 4;

  logic           clk, rst;
  logic [N-1:0]   req_issue_valid_i, req_issue_ready_o;
  logic [N*32-1:0] req_instr_i;
  logic [N*IW-1:0] req_id_i;
  logic [N*64-1:0] req_rs_i;
  logic [N*2-1:0]  req_rs_valid_i;
  logic           req_resp_accept_o, req_resp_writeback_o;
  logic [N-1:0]   req_commit_valid_i, req_commit_kill_i;
  logic [N-1:0]   req_result_valid_o, req_result_ready_i;
  logic [31:0]    req_result_data_o;
  logic [4:0]     req_result_rd_o;
  logic           req_result_we_o;
  logic [IW-1:0]  req_result_id_o;
  logic           cp_issue_valid_o, cp_issue_ready_i;
  logic [31:0]    cp_instr_o;
  logic [IW-1:0]  cp_id_o;
  logic [63:0]    cp_rs_o;
  logic [1:0]     cp_rs_valid_o;
  logic           cp_resp_accept_i, cp_resp_writeback_i;
  logic           cp_commit_valid_o, cp_commit_kill_o;
  logic [IW-1:0]  cp_commit_id_o;
  logic           cp_result_valid_i, cp_result_ready_o;
  logic [31:0]    cp_result_data_i;
  logic [4:0]     cp_result_rd_i;
  logic           cp_result_we_i;
  logic [IW-1:0]  cp_result_id_i;
  logic           busy_o;
  logic [0:0]     owner_o;
  logic           id_err_o, timeout_o;

  xif_coproc_arbiter #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_issue_valid_i(req_issue_valid_i), .req_issue_ready_o(req_issue_ready_o),
    .req_instr_i(req_instr_i), .req_id_i(req_id_i), .req_rs_i(req_rs_i),
    .req_rs_valid_i(req_rs_valid_i),
    .req_resp_accept_o(req_resp_accept_o), .req_resp_writeback_o(req_resp_writeback_o),
    .req_commit_valid_i(req_commit_valid_i), .req_commit_kill_i(req_commit_kill_i),
    .req_result_valid_o(req_result_valid_o), .req_result_ready_i(req_result_ready_i),
    .req_result_data_o(req_result_data_o), .req_result_rd_o(req_result_rd_o),
    .req_result_we_o(req_result_we_o), .req_result_id_o(req_result_id_o),
    .cp_issue_valid_o(cp_issue_valid_o), .cp_issue_ready_i(cp_issue_ready_i),
    .cp_instr_o(cp_instr_o), .cp_id_o(cp_id_o), .cp_rs_o(cp_rs_o),
    .cp_rs_valid_o(cp_rs_valid_o),
    .cp_resp_accept_i(cp_resp_accept_i), .cp_resp_writeback_i(cp_resp_writeback_i),
    .cp_commit_valid_o(cp_commit_valid_o), .cp_commit_kill_o(cp_commit_kill_o),
    .cp_commit_id_o(cp_commit_id_o),
    .cp_result_valid_i(cp_result_valid_i), .cp_result_ready_o(cp_result_ready_o),
    .cp_result_data_i(cp_result_data_i), .cp_result_rd_i(cp_result_rd_i),
    .cp_result_we_i(cp_result_we_i), .cp_result_id_i(cp_result_id_i),
    .busy_o(busy_o), .owner_o(owner_o), .id_err_o(id_err_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int m_rr  = 0;      // model round-robin pointer
  bit m_err = 0;      // model sticky id error
  bit m_to  = 0;      // model sticky timeout

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req_issue_valid_i  = '0; req_instr_i = '0; req_id_i = '0; req_rs_i = '0;
    req_rs_valid_i     = '0; req_commit_valid_i = '0; req_commit_kill_i = '0;
    req_result_ready_i = '0; cp_issue_ready_i = 0; cp_resp_accept_i = 0;
    cp_resp_writeback_i = 0; cp_result_valid_i = 0; cp_result_data_i = '0;
    cp_result_rd_i = '0; cp_result_we_i = 0; cp_result_id_i = '0;
  endtask

  // Starts in IDLE at negedge+1. Ends at negedge+1 in the state after commit.
  task automatic issue_phase(input logic [N-1:0] mask, input logic [IW-1:0] id,
                             input bit acc, input bit wb, input bit cs, input bit kill,
                             output int own, output bit go);
    own = -1;
    for (int i = 0; i < N; i++) if (own < 0 && mask[(m_rr + i) % N]) own = (m_rr + i) % N;
    for (int r = 0; r < N; r++) begin
      req_instr_i[r*32 +: 32]   = $urandom;
      req_rs_i[r*64 +: 64]      = {$urandom, $urandom};
      req_rs_valid_i[r*2 +: 2]  = 2'($urandom_range(0, 3));
      req_id_i[r*IW +: IW]      = IW'($urandom_range(0, 15));
    end
    req_id_i[own*IW +: IW] = id;
    req_issue_valid_i = mask;
    #1;
    chk("idle_busy", busy_o, 0);
    chk("idle_cp_valid", cp_issue_valid_o, 0);
    @(posedge clk);
    m_rr = (own + 1) % N;
    @(negedge clk); #1;
    chk("owner", owner_o, own);
    chk("iss_busy", busy_o, 1);
    chk("iss_cp_valid", cp_issue_valid_o, 1);
    chk("iss_instr", cp_instr_o, req_instr_i[own*32 +: 32]);
    chk("iss_id", cp_id_o, id);
    chk("iss_rs", cp_rs_o, req_rs_i[own*64 +: 64]);
    chk("iss_rsv", cp_rs_valid_o, req_rs_valid_i[own*2 +: 2]);
    chk("iss_rdy_low", req_issue_ready_o, 0);
    cp_issue_ready_i = 1; cp_resp_accept_i = acc; cp_resp_writeback_i = wb;
    if (cs) begin req_commit_valid_i[own] = 1; req_commit_kill_i[own] = kill; end
    #1;
    chk("iss_rdy", req_issue_ready_o, 64'(1 << own));
    chk("resp_acc", req_resp_accept_o, acc);
    chk("resp_wb", req_resp_writeback_o, wb);
    chk("iss_commit", cp_commit_valid_o, cs);
    if (cs) begin
      chk("iss_commit_id", cp_commit_id_o, id);
      chk("iss_commit_kill", cp_commit_kill_o, kill);
    end
    @(negedge clk); clear_inputs(); #1;
    if (!cs) begin
      chk("wc_busy", busy_o, 1);
      chk("wc_idle_commit", cp_commit_valid_o, 0);
      req_commit_valid_i[own] = 1; req_commit_kill_i[own] = kill;
      #1;
      chk("wc_commit", cp_commit_valid_o, 1);
      chk("wc_commit_id", cp_commit_id_o, id);
      chk("wc_commit_kill", cp_commit_kill_o, kill);
      @(negedge clk); clear_inputs(); #1;
    end
    go = acc && wb && !kill;
    chk("post_commit_busy", busy_o, go);
    chk("post_commit_pulse", cp_commit_valid_o, 0);
  endtask

  // Starts in WAIT_RESULT at negedge+1, ends in IDLE at negedge+1.
  task automatic result_phase(input int own, input logic [IW-1:0] id,
                              input logic [IW-1:0] resid, input int dly);
    logic [31:0] d;
    logic [4:0]  rd;
    for (int k = 0; k < dly; k++) begin
      chk("wr_no_valid", req_result_valid_o, 0);
      @(negedge clk); #1;
    end
    d = $urandom; rd = 5'($urandom_range(0, 31));
    cp_result_valid_i = 1; cp_result_data_i = d; cp_result_rd_i = rd;
    cp_result_we_i = 1; cp_result_id_i = resid; req_result_ready_i[own] = 1;
    #1;
    chk("res_valid", req_result_valid_o, 64'(1 << own));
    chk("res_data", req_result_data_o, d);
    chk("res_rd", req_result_rd_o, rd);
    chk("res_we", req_result_we_o, 1);
    chk("res_id", req_result_id_o, resid);
    chk("res_cp_ready", cp_result_ready_o, 1);
    @(posedge clk);
    if (resid != id) m_err = 1;
    @(negedge clk); clear_inputs(); #1;
    chk("res_busy", busy_o, 0);
    chk("id_err", id_err_o, m_err);
    chk("timeout", timeout_o, m_to);
  endtask

  initial begin
    int own; bit go;
    rst = 1; clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_id_err", id_err_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_cp_valid", cp_issue_valid_o, 0);
    rst = 0;
    @(negedge clk); #1;

    // Single transaction from req0 with a later commit.
    issue_phase(2'b01, 4'd3, 1, 1, 0, 0, own, go);
    chk("t1_owner", own, 0);
    req_instr_i = '0;
    if (go) begin
      for (int k = 0; k < 1; k++) ;
    end
    cp_result_valid_i = 1; cp_result_data_i = 32'hDEADBEEF; cp_result_rd_i = 5'd5;
    cp_result_we_i = 1; cp_result_id_i = 4'd3; req_result_ready_i = 2'b01;
    #1;
    chk("t1_valid", req_result_valid_o, 2'b01);
    chk("t1_data", req_result_data_o, 32'hDEADBEEF);
    chk("t1_rd", req_result_rd_o, 5);
    chk("t1_we", req_result_we_o, 1);
    @(negedge clk); clear_inputs(); #1;
    chk("t1_busy", busy_o, 0);

    // Fairness after reset: both valid, grants 0,1,0.
    rst = 1; #1; rst = 0; m_rr = 0;
    @(negedge clk); #1;
    for (int r = 0; r < 3; r++) begin
      issue_phase(2'b11, IW'(r + 1), 1, 1, 1, 0, own, go);
      chk("fair_owner", own, r % 2);
      result_phase(own, IW'(r + 1), IW'(r + 1), 0);
    end

    // Same-cycle commit with accept=0, then with kill=1: no result wait.
    issue_phase(2'b01, 4'd5, 0, 1, 1, 0, own, go);
    issue_phase(2'b01, 4'd6, 1, 1, 1, 1, own, go);

    // Result id mismatch sets a sticky flag; result is still delivered.
    issue_phase(2'b10, 4'd3, 1, 1, 0, 0, own, go);
    result_phase(own, 4'd3, 4'd7, 1);
    issue_phase(2'b01, 4'd9, 1, 1, 1, 0, own, go);
    result_phase(own, 4'd9, 4'd9, 0);

    // Requester withdraws issue before handshake: back to IDLE, no commit.
    req_issue_valid_i = 2'b10;
    @(posedge clk); m_rr = 0;
    @(negedge clk); req_issue_valid_i = '0; #1;
    chk("wd_cp_valid", cp_issue_valid_o, 0);
    @(negedge clk); #1;
    chk("wd_busy", busy_o, 0);
    chk("wd_commit", cp_commit_valid_o, 0);

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      logic [N-1:0] mask; logic [IW-1:0] id, rid; bit a, w, c, k;
      mask = 2'($urandom_range(1, 3));
      id = IW'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) != 0); w = ($urandom_range(0, 3) != 0);
      c = $urandom_range(0, 1) == 1;  k = ($urandom_range(0, 4) == 0);
      rid = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(0, 15)) : id;
      issue_phase(mask, id, a, w, c, k, own, go);
      if (go) result_phase(own, id, rid, $urandom_range(0, 3));
    end

`ifdef XIF_ARB_TIMEOUT_EN
    // Watchdog: no cp result for 16 cycles in WAIT_RESULT.
    issue_phase(2'b01, 4'd3, 1, 1, 1, 0, own, go);
    for (int c = 0; c < 15; c++) begin
      chk("to_wait", req_result_valid_o, 0);
      @(negedge clk); #1;
    end
    for (int c = 0; c < 2; c++) begin
      chk("to_valid", req_result_valid_o, 64'(1 << own));
      chk("to_we", req_result_we_o, 0);
      chk("to_data", req_result_data_o, 0);
      chk("to_id", req_result_id_o, 3);
      chk("to_cp_ready", cp_result_ready_o, 0);
      chk("to_flag_pre", timeout_o, 0);
      if (c == 0) begin @(negedge clk); #1; end
    end
    req_result_ready_i[own] = 1;
    @(posedge clk); m_to = 1;
    @(negedge clk); clear_inputs(); #1;
    chk("to_flag", timeout_o, 1);
    chk("to_busy", busy_o, 0);
`endif

    // Async reset while in WAIT_RESULT.
    issue_phase(2'b10, 4'd4, 1, 1, 1, 0, own, go);
    cp_result_valid_i = 1;
    #1;
    chk("pre_rst_valid", req_result_valid_o, 64'(1 << own));
    rst = 1; #1;
    chk("arst_valid", req_result_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_owner", owner_o, 0);
    chk("arst_id_err", id_err_o, 0);
    chk("arst_timeout", timeout_o, 0);
    m_rr = 0; m_err = 0; m_to = 0;
    clear_inputs();
    @(negedge clk); rst = 0; #1;
    issue_phase(2'b11, 4'd2, 1, 1, 0, 0, own, go);
    chk("post_rst_owner", own, 0);
    result_phase(own, 4'd2, 4'd2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/xif_coproc_arbiter.md
Name: xif_coproc_arbiter

Overview:
- Shares one CORE-V-XIF coprocessor between NUM_REQ CPU-side X-IF masters, for example several CV32E20 cores.
- Covers the issue, commit and result channels only; compressed and memory channels are not handled.
- Round-robin arbitration with a single transaction in flight; commit and result are routed back to the owning requester.
- Sits between the cores' XIF wrappers and the shared coprocessor in the core-v-mini-mcu.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ID_W, 4, X-IF instruction id width.
- TIMEOUT_CYCLES, 1024, result watchdog limit; used only with XIF_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_issue_valid_i  in  NUM_REQ  per-requester issue valid.
- req_issue_ready_o  out  NUM_REQ  per-requester issue ready.
- req_instr_i  in  NUM_REQ*32  instruction.
- req_id_i  in  NUM_REQ*ID_W  instruction id.
- req_rs_i  in  NUM_REQ*64  rs0/rs1 operands.
- req_rs_valid_i  in  NUM_REQ*2  operand valids.
- req_resp_accept_o  out  1  broadcast accept.
- req_resp_writeback_o  out  1  broadcast writeback.
- req_commit_valid_i  in  NUM_REQ  commit valid.
- req_commit_kill_i  in  NUM_REQ  commit kill.
- req_result_valid_o  out  NUM_REQ  result valid.
- req_result_ready_i  in  NUM_REQ  result ready.
- req_result_data_o  out  32  broadcast result data.
- req_result_rd_o  out  5  broadcast destination register.
- req_result_we_o  out  1  broadcast write enable.
- req_result_id_o  out  ID_W  broadcast result id.
- cp_issue_valid_o / cp_issue_ready_i  out/in  1  coprocessor issue handshake.
- cp_instr_o  out  32  instruction to coprocessor.
- cp_id_o  out  ID_W  id to coprocessor.
- cp_rs_o  out  64  operands to coprocessor.
- cp_rs_valid_o  out  2  operand valids to coprocessor.
- cp_resp_accept_i / cp_resp_writeback_i  in  1  coprocessor issue response.
- cp_commit_valid_o / cp_commit_kill_o / cp_commit_id_o  out  1/1/ID_W  commit to coprocessor.
- cp_result_valid_i / cp_result_ready_o  in/out  1  coprocessor result handshake.
- cp_result_data_i / cp_result_rd_i / cp_result_we_i / cp_result_id_i  in  32/5/1/ID_W  coprocessor result.
- busy_o  out  1  transaction in flight.
- owner_o  out  $clog2(NUM_REQ)  current owner.
- id_err_o  out  1  sticky result-id mismatch flag.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, rst_i=1) sets:
  - state=IDLE, rr_ptr=0, owner=0, latched id/accept/writeback=0;
  - id_err_o=0, timeout_o=0;
  - all valid/ready/outputs=0.
- IDLE:
  - Grant goes to the first requester with issue_valid, searching from rr_ptr upward with wrap.
  - The grant is registered: owner and rr_ptr=(grant+1)%NUM_REQ are latched; state becomes ISSUE next cycle.
  - No valid: stay in IDLE, rr_ptr unchanged. Nothing is forwarded while in IDLE.
- ISSUE:
  - cp_issue_valid_o=req_issue_valid_i[owner]; payload is muxed combinationally from owner.
  - req_issue_ready_o[owner]=cp_issue_ready_i; all other readies are 0.
  - The requester holds its payload stable while valid, per X-IF.
  - The accept/writeback broadcast is qualified by the owner's ready.
  - On handshake, cp_id, accept and writeback are latched.
  - If the owner's commit_valid is high in the handshake cycle, it is forwarded to cp in that same cycle and the next-state rule below applies directly.
  - Otherwise state becomes WAIT_COMMIT.
- WAIT_COMMIT:
  - cp_commit_valid_o=req_commit_valid_i[owner]; kill is passed through; cp_commit_id_o=latched id.
  - On commit, next state is:
    - IDLE if kill, !accept or !writeback;
    - WAIT_RESULT otherwise.
- WAIT_RESULT:
  - req_result_valid_o[owner]=cp_result_valid_i; cp_result_ready_o=req_result_ready_i[owner]; result fields are broadcast.
  - On handshake, state becomes IDLE.
  - If cp_result_id_i != latched id at handshake, set id_err_o (sticky until reset); the result is still delivered.
- Other rules:
  - busy_o=(state!=IDLE); owner_o reflects the latched owner.
  - A requester that drops issue_valid before handshake in ISSUE (protocol violation) sends the block back to IDLE next cycle with no commit.
  - Fairness: with all requesters always valid, grants rotate 0,1,...,NUM_REQ-1,0.

Optional Feature:
- Macro: XIF_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to WAIT_RESULT and increments each cycle there without a result handshake.
  - When the counter reaches TIMEOUT_CYCLES-1, the block drives req_result_valid_o[owner]=1 for one beat with we=0, data=0 and id=latched id, waiting for ready.
  - It also sets timeout_o (sticky) and returns to IDLE.
  - cp_result_ready_o=0 during that beat.
- When undefined: no counter is built, timeout_o is tied to 0, and WAIT_RESULT waits indefinitely.

Test Plan:
1. Req0 issues 0x0000_000B with id=3, accept=1, writeback=1; commit kill=0; cp result data=0xDEADBEEF, rd=5 -> req0 sees result_valid with data 0xDEADBEEF, rd=5, we=1; busy_o returns to 0; no output to req1.
2. Req0 and req1 valid in the same IDLE cycle after reset -> req0 granted first; req1 granted on the next IDLE; a third round goes to req0; owner_o follows 0,1,0.
3. Issue handshake with accept=0 plus commit in the same cycle -> cp_commit_valid_o pulses once and state is IDLE next cycle with no result wait; the same path is checked with accept=1 and commit kill=1.
4. cp_result_id_i=7 while the latched id is 3 -> result delivered, id_err_o=1 and held through subsequent transactions until rst_i.
5. With XIF_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, cp never returns a result -> after 16 cycles in WAIT_RESULT the owner receives a we=0 result with id=3, timeout_o=1, and busy_o drops.
6. rst_i asserted while in WAIT_RESULT -> all outputs are 0 in the same cycle (async), state=IDLE, rr_ptr=0, and a new issue is accepted normally after release.
